// File: rtl/wb_arb_pkg.sv
// wb_arb_pkg
// Shared types and constants for the two-master Wishbone arbiter:
//   arb_state_e  - arbiter state (IDLE / GRANT / ABORT)
//   OWNER_A/B    - encoding of the owner and last_owner bits
//   other_owner  - returns the opposite master
package wb_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_ABORT = 2'd2
  } arb_state_e;

  localparam logic OWNER_A = 1'b0;
  localparam logic OWNER_B = 1'b1;

  function automatic logic other_owner(input logic owner);
    return ~owner;
  endfunction

endpackage

// File: rtl/wb_arb_watchdog.sv
// wb_arb_watchdog
// Tracks outstanding requests of the current bus owner and times out a
// cycle whose slave has stopped acknowledging.
// Ports:
//   i_clk, i_reset  clock, synchronous active-high reset
//   accept_i        a request was accepted by the slave this cycle
//   ack_i           the slave acknowledged a request this cycle
//   err_i           the slave signalled a bus error (drops all outstanding)
//   clear_i         no cycle in progress; forget all state
//   full_o          outstanding count has reached 2^LGMAXOUT-1
//   timeout_o       TIMEOUT cycles without ack while requests are pending
module wb_arb_watchdog #(
  parameter int LGMAXOUT = 4,
  parameter int TIMEOUT  = 64
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic accept_i,
  input  logic ack_i,
  input  logic err_i,
  input  logic clear_i,
  output logic full_o,
  output logic timeout_o
);

  localparam int WDW = $clog2(TIMEOUT);
  localparam logic [LGMAXOUT-1:0] CNT_MAX = '1;
  localparam logic [WDW-1:0]      WD_LAST = WDW'(TIMEOUT - 1);

  logic [LGMAXOUT-1:0] count_q, count_d;
  logic [WDW-1:0]      wd_q, wd_d;

  always_comb begin
    count_d = count_q;
    if (clear_i || err_i)
      count_d = '0;
    else if (accept_i && !ack_i)
      count_d = count_q + LGMAXOUT'(1);
    else if (ack_i && !accept_i && (count_q != '0))
      count_d = count_q - LGMAXOUT'(1);
  end

  // The timer only runs while something is pending; any ack restarts it.
  // It parks at WD_LAST so it cannot wrap back into a false "alive" state.
  always_comb begin
    wd_d = wd_q;
    if (clear_i || (count_q == '0) || ack_i)
      wd_d = '0;
    else if (wd_q != WD_LAST)
      wd_d = wd_q + WDW'(1);
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      count_q <= '0;
      wd_q    <= '0;
    end else begin
      count_q <= count_d;
      wd_q    <= wd_d;
    end
  end

  assign full_o    = (count_q == CNT_MAX);
  assign timeout_o = (count_q != '0) && (wd_q == WD_LAST) && !ack_i;

endmodule

// File: rtl/wb_arbiter_2m.sv
// wb_arbiter_2m
// Shares one pipelined Wishbone (B4) peripheral bus between master A (CPU)
// and master B (debug/DMA). Whole bus cycles are granted; simultaneous
// requests are resolved round-robin. A stuck slave is detected by the
// watchdog and the owner's cycle is aborted with a one-cycle error.
// Ports:
//   i_clk, i_reset                     clock, synchronous active-high reset
//   i_a_* / o_a_*                      master A request / response
//   i_b_* / o_b_*                      master B request / response
//   o_wb_*                             slave-side request
//   i_wb_ack/stall/err/data            slave-side response
module wb_arbiter_2m
  import wb_arb_pkg::*;
#(
  parameter int AW       = 30,
  parameter int DW       = 32,
  parameter int LGMAXOUT = 4,
  parameter int TIMEOUT  = 64
) (
  input  logic            i_clk,
  input  logic            i_reset,
  // master A
  input  logic            i_a_cyc,
  input  logic            i_a_stb,
  input  logic            i_a_we,
  input  logic [AW-1:0]   i_a_addr,
  input  logic [DW-1:0]   i_a_data,
  input  logic [DW/8-1:0] i_a_sel,
  output logic            o_a_ack,
  output logic            o_a_stall,
  output logic            o_a_err,
  output logic [DW-1:0]   o_a_data,
  // master B
  input  logic            i_b_cyc,
  input  logic            i_b_stb,
  input  logic            i_b_we,
  input  logic [AW-1:0]   i_b_addr,
  input  logic [DW-1:0]   i_b_data,
  input  logic [DW/8-1:0] i_b_sel,
  output logic            o_b_ack,
  output logic            o_b_stall,
  output logic            o_b_err,
  output logic [DW-1:0]   o_b_data,
  // slave side
  output logic            o_wb_cyc,
  output logic            o_wb_stb,
  output logic            o_wb_we,
  output logic [AW-1:0]   o_wb_addr,
  output logic [DW-1:0]   o_wb_data,
  output logic [DW/8-1:0] o_wb_sel,
  input  logic            i_wb_ack,
  input  logic            i_wb_stall,
  input  logic            i_wb_err,
  input  logic [DW-1:0]   i_wb_data
);

  arb_state_e state_q;
  logic       owner_q;
  logic       last_owner_q;

  // Owner-selected request
  logic            own_cyc, own_stb, own_we, other_cyc;
  logic [AW-1:0]   own_addr;
  logic [DW-1:0]   own_wdata;
  logic [DW/8-1:0] own_sel;

  assign own_cyc   = (owner_q == OWNER_B) ? i_b_cyc  : i_a_cyc;
  assign own_stb   = (owner_q == OWNER_B) ? i_b_stb  : i_a_stb;
  assign own_we    = (owner_q == OWNER_B) ? i_b_we   : i_a_we;
  assign own_addr  = (owner_q == OWNER_B) ? i_b_addr : i_a_addr;
  assign own_wdata = (owner_q == OWNER_B) ? i_b_data : i_a_data;
  assign own_sel   = (owner_q == OWNER_B) ? i_b_sel  : i_a_sel;
  assign other_cyc = (owner_q == OWNER_B) ? i_a_cyc  : i_b_cyc;

  logic granted, active, full, timeout, abort, accept;

  assign granted = (state_q == ST_GRANT);
  // Slave cyc follows the owner's cyc combinationally so it drops the same
  // cycle the owner releases the bus.
  assign active  = granted && own_cyc;
  assign abort   = active && timeout;

  // Slave-side request
  assign o_wb_cyc  = active;
  assign o_wb_stb  = active && own_stb && !full;
  assign o_wb_we   = granted && own_we;
  assign o_wb_addr = granted ? own_addr  : '0;
  assign o_wb_data = granted ? own_wdata : '0;
  assign o_wb_sel  = granted ? own_sel   : '0;

  assign accept = o_wb_stb && !i_wb_stall;

  // Acks/errors outside GRANT (e.g. late acks after an abort) are dropped
  // here so they neither reach a master nor disturb the counters.
  wb_arb_watchdog #(
    .LGMAXOUT (LGMAXOUT),
    .TIMEOUT  (TIMEOUT)
  ) u_watchdog (
    .i_clk     (i_clk),
    .i_reset   (i_reset),
    .accept_i  (accept),
    .ack_i     (granted && i_wb_ack),
    .err_i     (granted && i_wb_err),
    .clear_i   (!active),
    .full_o    (full),
    .timeout_o (timeout)
  );

  // Response seen by the owner; the non-owner always sees a stalled, idle bus.
  logic          own_stall, own_ack, own_err;
  logic [DW-1:0] own_rdata;

  assign own_stall = !granted || i_wb_stall || full;
  assign own_ack   = granted && i_wb_ack;
  assign own_err   = granted && (i_wb_err || abort);
  assign own_rdata = granted ? i_wb_data : '0;

  assign o_a_stall = (owner_q == OWNER_A) ? own_stall : 1'b1;
  assign o_a_ack   = (owner_q == OWNER_A) && own_ack;
  assign o_a_err   = (owner_q == OWNER_A) && own_err;
  assign o_a_data  = (owner_q == OWNER_A) ? own_rdata : '0;

  assign o_b_stall = (owner_q == OWNER_B) ? own_stall : 1'b1;
  assign o_b_ack   = (owner_q == OWNER_B) && own_ack;
  assign o_b_err   = (owner_q == OWNER_B) && own_err;
  assign o_b_data  = (owner_q == OWNER_B) ? own_rdata : '0;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q      <= ST_IDLE;
      owner_q      <= OWNER_A;
      last_owner_q <= OWNER_B;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (i_a_cyc && i_b_cyc) begin
            owner_q <= other_owner(last_owner_q);
            state_q <= ST_GRANT;
          end else if (i_a_cyc) begin
            owner_q <= OWNER_A;
            state_q <= ST_GRANT;
          end else if (i_b_cyc) begin
            owner_q <= OWNER_B;
            state_q <= ST_GRANT;
          end
        end
        ST_GRANT: begin
          last_owner_q <= owner_q;
          if (!own_cyc) begin
            // Hand straight over to a waiting master, no idle bubble.
            if (other_cyc)
              owner_q <= other_owner(owner_q);
            else
              state_q <= ST_IDLE;
          end else if (timeout) begin
            state_q <= ST_ABORT;
          end
        end
        ST_ABORT: begin
          if (!own_cyc)
            state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_arbiter_2m.sv
module tb_wb_arbiter_2m;

  localparam int AW = 30;
  localparam int DW = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic            a_cyc, a_stb, a_we, b_cyc, b_stb, b_we;
  logic [AW-1:0]   a_addr, b_addr;
  logic [DW-1:0]   a_wdata, b_wdata;
  logic [DW/8-1:0] a_sel, b_sel;
  logic            a_ack, a_stall, a_err, b_ack, b_stall, b_err;
  logic [DW-1:0]   a_rdata, b_rdata;
  logic            wb_cyc, wb_stb, wb_we;
  logic [AW-1:0]   wb_addr;
  logic [DW-1:0]   wb_wdata;
  logic [DW/8-1:0] wb_sel;
  logic            wb_ack, wb_stall, wb_err;
  logic [DW-1:0]   wb_rdata;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  wb_arbiter_2m #(
    .AW       (AW),
    .DW       (DW),
    .LGMAXOUT (2),
    .TIMEOUT  (8)
  ) dut (
    .i_clk      (clk),
    .i_reset    (rst),
    .i_a_cyc    (a_cyc),
    .i_a_stb    (a_stb),
    .i_a_we     (a_we),
    .i_a_addr   (a_addr),
    .i_a_data   (a_wdata),
    .i_a_sel    (a_sel),
    .o_a_ack    (a_ack),
    .o_a_stall  (a_stall),
    .o_a_err    (a_err),
    .o_a_data   (a_rdata),
    .i_b_cyc    (b_cyc),
    .i_b_stb    (b_stb),
    .i_b_we     (b_we),
    .i_b_addr   (b_addr),
    .i_b_data   (b_wdata),
    .i_b_sel    (b_sel),
    .o_b_ack    (b_ack),
    .o_b_stall  (b_stall),
    .o_b_err    (b_err),
    .o_b_data   (b_rdata),
    .o_wb_cyc   (wb_cyc),
    .o_wb_stb   (wb_stb),
    .o_wb_we    (wb_we),
    .o_wb_addr  (wb_addr),
    .o_wb_data  (wb_wdata),
    .o_wb_sel   (wb_sel),
    .i_wb_ack   (wb_ack),
    .i_wb_stall (wb_stall),
    .i_wb_err   (wb_err),
    .i_wb_data  (wb_rdata)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Inputs change 1ns after the rising edge; outputs are sampled 1ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    a_cyc = 0; a_stb = 0; a_we = 0; a_addr = '0; a_wdata = '0; a_sel = '0;
    b_cyc = 0; b_stb = 0; b_we = 0; b_addr = '0; b_wdata = '0; b_sel = '0;
    wb_ack = 0; wb_stall = 0; wb_err = 0; wb_rdata = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1;
    tick();
    rst = 0;
  endtask

  initial begin
    idle_inputs();
    rst = 1;
    tick();
    tick();
    rst = 0;
    #1;
    check("rst_a_stall", a_stall, 1);
    check("rst_b_stall", b_stall, 1);
    check("rst_wb_cyc", wb_cyc, 0);
    check("rst_a_ack", a_ack, 0);
    check("rst_wb_addr", wb_addr, 0);

    // ---- single master write ----
    a_cyc = 1; a_stb = 1; a_we = 1; a_addr = 30'h100; a_wdata = 32'hAA; a_sel = 4'hF;
    #1;
    check("wr_idle_cyc", wb_cyc, 0);
    check("wr_idle_stall", a_stall, 1);
    tick();
    #1;
    check("wr_grant_cyc", wb_cyc, 1);
    check("wr_grant_stb", wb_stb, 1);
    check("wr_data", wb_wdata, 32'hAA);
    check("wr_addr", wb_addr, 30'h100);
    check("wr_we", wb_we, 1);
    check("wr_a_stall", a_stall, 0);
    check("wr_b_stall", b_stall, 1);
    tick();
    a_stb = 0; wb_ack = 1;
    #1;
    check("wr_a_ack", a_ack, 1);
    check("wr_b_ack", b_ack, 0);
    check("wr_stb_low", wb_stb, 0);
    tick();
    a_cyc = 0; wb_ack = 0;
    #1;
    check("wr_ack_pulse", a_ack, 0);
    check("wr_cyc_drop", wb_cyc, 0);
    tick();

    // ---- contention from reset ----
    do_reset();
    a_cyc = 1; b_cyc = 1; a_addr = 30'h10; b_addr = 30'h20;
    tick();
    #1;
    check("ct_first_addr", wb_addr, 30'h10);
    check("ct_first_a_stall", a_stall, 0);
    check("ct_first_b_stall", b_stall, 1);
    a_cyc = 0;
    #1;
    check("ct_drop_cyc", wb_cyc, 0);
    tick();
    #1;
    check("ct_hand_cyc", wb_cyc, 1);
    check("ct_hand_addr", wb_addr, 30'h20);
    check("ct_hand_b_stall", b_stall, 0);
    check("ct_hand_a_stall", a_stall, 1);
    b_cyc = 0;
    tick();
    a_cyc = 1;
    tick();
    a_cyc = 0;
    tick();
    a_cyc = 1; b_cyc = 1;
    tick();
    #1;
    check("ct2_addr", wb_addr, 30'h20);
    check("ct2_b_stall", b_stall, 0);
    check("ct2_a_stall", a_stall, 1);
    a_cyc = 0; b_cyc = 0;
    tick();

    // ---- pipelined read burst ----
    a_cyc = 1; a_stb = 1; a_we = 0; a_addr = 30'h40;
    tick();
    for (int k = 1; k <= 5; k++) begin
      a_stb = (k <= 4);
      a_addr = 30'h40 + 30'(k - 1);
      wb_ack = (k >= 2);
      wb_rdata = 32'(k - 1);
      #1;
      if (k >= 2) begin
        check($sformatf("bu_ack%0d", k - 1), a_ack, 1);
        check($sformatf("bu_data%0d", k - 1), a_rdata, 64'(k - 1));
      end
      check($sformatf("bu_err%0d", k), a_err, 0);
      check($sformatf("bu_stall%0d", k), a_stall, 0);
      tick();
    end
    a_stb = 0; wb_ack = 0; wb_rdata = '0;
    // Nothing outstanding: holding the bus must never trip the watchdog.
    for (int k = 0; k < 10; k++) begin
      #1;
      check($sformatf("bu_hold_err%0d", k), a_err, 0);
      tick();
    end
    a_cyc = 0;
    tick();

    // ---- outstanding limit (3 with LGMAXOUT=2) ----
    a_cyc = 1; a_stb = 1;
    tick();
    #1;
    check("fu_acc1_stall", a_stall, 0);
    tick();
    tick();
    #1;
    check("fu_acc3_stb", wb_stb, 1);
    tick();
    wb_ack = 1;
    #1;
    check("fu_full_stall", a_stall, 1);
    check("fu_full_stb", wb_stb, 0);
    check("fu_full_ack", a_ack, 1);
    tick();
    wb_ack = 0;
    #1;
    check("fu_reopen_stall", a_stall, 0);
    check("fu_reopen_stb", wb_stb, 1);
    tick();
    #1;
    check("fu_refull_stall", a_stall, 1);
    check("fu_refull_stb", wb_stb, 0);
    a_cyc = 0; a_stb = 0;
    tick();

    // ---- timeout on B ----
    do_reset();
    b_cyc = 1; b_stb = 1; b_we = 0; b_addr = 30'h30;
    tick();
    a_cyc = 1;
    #1;
    check("to_b_stall", b_stall, 0);
    check("to_accept_stb", wb_stb, 1);
    tick();
    b_stb = 0;
    for (int k = 1; k <= 8; k++) begin
      #1;
      check($sformatf("to_err_t%0d", k), b_err, (k == 8) ? 1 : 0);
      if (k == 8)
        check("to_cyc_at_err", wb_cyc, 1);
      tick();
    end
    wb_ack = 1;
    #1;
    check("to_abort_cyc", wb_cyc, 0);
    check("to_abort_err", b_err, 0);
    check("to_late_ack", b_ack, 0);
    check("to_abort_b_stall", b_stall, 1);
    check("to_abort_a_stall", a_stall, 1);
    tick();
    wb_ack = 0; b_cyc = 0;
    #1;
    check("to_abort2_cyc", wb_cyc, 0);
    tick();
    #1;
    check("to_idle_a_stall", a_stall, 1);
    check("to_idle_cyc", wb_cyc, 0);
    tick();
    #1;
    check("to_a_grant_cyc", wb_cyc, 1);
    check("to_a_grant_stall", a_stall, 0);
    a_cyc = 0;
    tick();

    // ---- reset in the middle of a burst ----
    a_cyc = 1; a_stb = 1; a_addr = 30'h50;
    tick();
    tick();
    tick();
    a_stb = 0; rst = 1;
    tick();
    rst = 0; wb_ack = 1;
    #1;
    check("mr_cyc", wb_cyc, 0);
    check("mr_a_stall", a_stall, 1);
    check("mr_b_stall", b_stall, 1);
    check("mr_late_ack", a_ack, 0);
    tick();
    wb_ack = 0;
    #1;
    check("mr_regrant_cyc", wb_cyc, 1);
    check("mr_regrant_ack", a_ack, 0);
    a_cyc = 0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
